// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the four-way round-robin bus arbiter.
package arb_pkg;
    localparam int NUM_REQ     = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational circular picker: first set req bit at or after start, wrapping mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       hit,
    output logic [1:0] idx
);
    logic [1:0] cand;

    always_comb begin
        hit  = 1'b0;
        idx  = start;
        cand = start;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = start + 2'(i);
            if (!hit && req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/bus_arb4.sv
// Four-requester round-robin bus arbiter with registered one-hot grant.
// Define ARB_TIMEOUT_EN to build the per-grant watchdog that revokes stuck grants.
module bus_arb4
    import arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic             done,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [WIDTH-1:0] bus_out,
    output logic             timeout
);
    state_t     state;
    logic [1:0] last;
    logic [1:0] start;
    logic       pick_hit;
    logic [1:0] pick_idx;
    logic       expire;
    logic       release_now;
    logic       new_grant;

    // While busy, searching from sel+1 puts the releasing index last in line.
    assign start       = (state == BUSY) ? sel + 2'd1 : last + 2'd1;
    assign release_now = (state == BUSY) && (done || !req[sel] || expire);
    assign new_grant   = pick_hit && ((state == IDLE) || release_now);

    rr_pick4 u_pick (
        .req   (req),
        .start (start),
        .hit   (pick_hit),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= 4'b0000;
            sel   <= 2'd0;
            busy  <= 1'b0;
            last  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        state <= BUSY;
                        grant <= 4'b0001 << pick_idx;
                        sel   <= pick_idx;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        last <= sel;
                        if (pick_hit) begin
                            grant <= 4'b0001 << pick_idx;
                            sel   <= pick_idx;
                        end else begin
                            state <= IDLE;
                            grant <= 4'b0000;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt;
    logic          tmo;

    assign expire  = (state == BUSY) && (cnt == CW'(TIMEOUT - 1));
    assign timeout = tmo;

    // A done arriving with the expiry wins, so no pulse in that case.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            tmo <= 1'b0;
        end else begin
            tmo <= expire && !done;
            if (new_grant || state == IDLE) cnt <= '0;
            else                            cnt <= cnt + 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        bus_out = '0;
        if (busy) begin
            case (sel)
                2'd0:    bus_out = d0;
                2'd1:    bus_out = d1;
                2'd2:    bus_out = d2;
                default: bus_out = d3;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arb4.sv
// Directed bench for bus_arb4: arbitration order, release paths, reset abort, watchdog.
module tb_bus_arb4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic             done;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic             busy;
    logic [WIDTH-1:0] bus_out;
    logic             timeout;

    int n_vec = 0;
    int n_err = 0;

    bus_arb4 #(.WIDTH(WIDTH), .TIMEOUT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .bus_out (bus_out),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] s,
                               input logic b, input logic [WIDTH-1:0] bo);
        check({tag, ".grant"}, 64'(grant), 64'(g));
        check({tag, ".sel"}, 64'(sel), 64'(s));
        check({tag, ".busy"}, 64'(busy), 64'(b));
        check({tag, ".bus_out"}, 64'(bus_out), 64'(bo));
    endtask

    initial begin
        d0 = 32'hA0A0_0000;
        d1 = 32'hB1B1_1111;
        d2 = 32'hC2C2_2222;
        d3 = 32'hD3D3_3333;

        // Reset state, then first grant from last=3 picks requester 1 out of 1010.
        do_reset();
        check_grant("rst", 4'b0000, 2'd0, 1'b0, '0);
        check("rst.timeout", 64'(timeout), 64'd0);
        req = 4'b1010;
        step();
        check_grant("first", 4'b0010, 2'd1, 1'b1, 32'hB1B1_1111);
        req = 4'b0000;
        step();
        check_grant("drop_idle", 4'b0000, 2'd1, 1'b0, '0);

        // Full contention with done held: 0,1,2,3,0 back to back.
        do_reset();
        req = 4'b1111;
        step();
        check_grant("rr0", 4'b0001, 2'd0, 1'b1, 32'hA0A0_0000);
        done = 1'b1;
        step();
        check_grant("rr1", 4'b0010, 2'd1, 1'b1, 32'hB1B1_1111);
        step();
        check_grant("rr2", 4'b0100, 2'd2, 1'b1, 32'hC2C2_2222);
        step();
        check_grant("rr3", 4'b1000, 2'd3, 1'b1, 32'hD3D3_3333);
        step();
        check_grant("rr4", 4'b0001, 2'd0, 1'b1, 32'hA0A0_0000);
        done = 1'b0;
        req  = 4'b0000;
        step();
        check_grant("rr_end", 4'b0000, 2'd0, 1'b0, '0);

        // Grant to 2, drop req[2]: idle, and last=2 makes 3 win over 0 and 1.
        do_reset();
        req = 4'b0100;
        step();
        check_grant("g2", 4'b0100, 2'd2, 1'b1, 32'hC2C2_2222);
        req = 4'b0000;
        step();
        check_grant("g2_drop", 4'b0000, 2'd2, 1'b0, '0);
        req = 4'b1011;
        step();
        check_grant("after_last2", 4'b1000, 2'd3, 1'b1, 32'hD3D3_3333);
        // Dropping req[3] with others pending hands over directly to 0.
        req = 4'b0011;
        step();
        check_grant("drop_handover", 4'b0001, 2'd0, 1'b1, 32'hA0A0_0000);

        // Reset mid-transfer aborts without a pulse, then regrants one cycle after release.
        do_reset();
        req = 4'b0100;
        step();
        check_grant("pre_abort", 4'b0100, 2'd2, 1'b1, 32'hC2C2_2222);
        reset = 1'b1;
        step();
        check_grant("abort", 4'b0000, 2'd0, 1'b0, '0);
        check("abort.timeout", 64'(timeout), 64'd0);
        reset = 1'b0;
        step();
        check_grant("regrant", 4'b0100, 2'd2, 1'b1, 32'hC2C2_2222);

        // done while idle does nothing.
        do_reset();
        done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_grant("idle_done", 4'b0000, 2'd0, 1'b0, '0);
        end
        done = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // No done for 16 busy cycles: revoked, handed to 1, one-cycle pulse.
        do_reset();
        req = 4'b0011;
        step();
        check_grant("wd_g0", 4'b0001, 2'd0, 1'b1, 32'hA0A0_0000);
        for (int i = 1; i < 16; i++) begin
            step();
            check("wd_hold.grant", 64'(grant), 64'(4'b0001));
            check("wd_hold.timeout", 64'(timeout), 64'd0);
        end
        step();
        check_grant("wd_revoke", 4'b0010, 2'd1, 1'b1, 32'hB1B1_1111);
        check("wd_pulse", 64'(timeout), 64'd1);
        step();
        check("wd_pulse_end", 64'(timeout), 64'd0);
        check("wd_newgrant", 64'(grant), 64'(4'b0010));

        // done on the 16th cycle takes precedence: same handover, no pulse.
        do_reset();
        req = 4'b0011;
        step();
        for (int i = 1; i < 16; i++) step();
        check("wd_done_pre", 64'(grant), 64'(4'b0001));
        done = 1'b1;
        step();
        done = 1'b0;
        check_grant("wd_done", 4'b0010, 2'd1, 1'b1, 32'hB1B1_1111);
        check("wd_done.timeout", 64'(timeout), 64'd0);
        step();
        check("wd_done_after.timeout", 64'(timeout), 64'd0);
`else
        // Without the watchdog a grant is unbounded and timeout stays low.
        do_reset();
        req = 4'b0011;
        step();
        for (int i = 0; i < 24; i++) begin
            step();
            check("nowd.timeout", 64'(timeout), 64'd0);
        end
        check_grant("nowd_hold", 4'b0001, 2'd0, 1'b1, 32'hA0A0_0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
